// File: rtl/ddr_burst_arbiter.sv
// Arbitrates four cache-side requesters onto the single DDR controller burst port.
// Winner is latched at grant, held through BURST, and acknowledged with a one-cycle done pulse.
module ddr_burst_arbiter #(
  parameter int DDR_ADDR_WIDTH  = 28,
  parameter int BURST_LEN_WIDTH = 10,
  parameter int TIMEOUT_CYCLES  = 1023
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       init_calib_complete,
  input  logic                       ins_read_req,
  input  logic [DDR_ADDR_WIDTH-1:0]  ins_read_addr,
  input  logic [7:0]                 ins_read_len,
  input  logic                       data_read_req,
  input  logic [DDR_ADDR_WIDTH-1:0]  data_read_addr,
  input  logic [BURST_LEN_WIDTH-1:0] data_read_len,
  input  logic                       jmp_addr_read_req,
  input  logic                       data_store_req,
  input  logic [DDR_ADDR_WIDTH-1:0]  data_write_addr,
  input  logic [BURST_LEN_WIDTH-1:0] data_write_len,
  input  logic                       rd_burst_finish,
  input  logic                       wr_burst_finish,
  output logic                       rd_burst_req,
  output logic                       wr_burst_req,
  output logic [DDR_ADDR_WIDTH-1:0]  rd_burst_addr,
  output logic [BURST_LEN_WIDTH-1:0] rd_burst_len,
  output logic [DDR_ADDR_WIDTH-1:0]  wr_burst_addr,
  output logic [BURST_LEN_WIDTH-1:0] wr_burst_len,
  output logic [3:0]                 grant,
  output logic [3:0]                 done,
  output logic                       busy,
  output logic                       timeout_err,
  output logic [1:0]                 state_dbg
);

  // Handshake: rd/wr_burst_req rises with grant and holds until the matching
  // finish pulse (or watchdog expiry); the request drops on the edge after finish.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t                     state;
  logic                       rr_data;
  logic                       len_zero;
  logic [CNT_W-1:0]           wd_cnt;
  logic [3:0]                 win;
  logic [DDR_ADDR_WIDTH-1:0]  rd_addr_sel;
  logic [BURST_LEN_WIDTH-1:0] rd_len_sel;
  logic                       match_finish;

  assign state_dbg = state;

  // rr_data=1 means data read is preferred over instruction read on a tie.
  always_comb begin
    win = 4'b0000;
    if (data_store_req)
      win = 4'b1000;
    else if (jmp_addr_read_req)
      win = 4'b0100;
    else if (data_read_req && (!ins_read_req || rr_data))
      win = 4'b0010;
    else if (ins_read_req)
      win = 4'b0001;
  end

  always_comb begin
    rd_addr_sel = win[0] ? ins_read_addr : data_read_addr;
    if (win[2])
      rd_len_sel = BURST_LEN_WIDTH'(1);
    else if (win[1])
      rd_len_sel = data_read_len;
    else
      rd_len_sel = BURST_LEN_WIDTH'(ins_read_len);
  end

  assign match_finish = grant[3] ? wr_burst_finish : rd_burst_finish;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      rr_data       <= 1'b0;
      len_zero      <= 1'b0;
      wd_cnt        <= '0;
      rd_burst_req  <= 1'b0;
      wr_burst_req  <= 1'b0;
      rd_burst_addr <= '0;
      rd_burst_len  <= '0;
      wr_burst_addr <= '0;
      wr_burst_len  <= '0;
      grant         <= 4'b0000;
      done          <= 4'b0000;
      busy          <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 4'b0000;
          if (init_calib_complete && (win != 4'b0000)) begin
            grant  <= win;
            busy   <= 1'b1;
            wd_cnt <= '0;
            state  <= S_BURST;
            if (win[3]) begin
              wr_burst_addr <= data_write_addr;
              wr_burst_len  <= data_write_len;
              wr_burst_req  <= (data_write_len != '0);
              len_zero      <= (data_write_len == '0);
            end else begin
              rd_burst_addr <= rd_addr_sel;
              rd_burst_len  <= rd_len_sel;
              rd_burst_req  <= (rd_len_sel != '0);
              len_zero      <= (rd_len_sel == '0);
            end
          end
        end
        S_BURST: begin
          if (len_zero || match_finish) begin
            rd_burst_req <= 1'b0;
            wr_burst_req <= 1'b0;
            done         <= grant;
            state        <= S_DONE;
          end else if (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            rd_burst_req <= 1'b0;
            wr_burst_req <= 1'b0;
            timeout_err  <= 1'b1;
            done         <= grant;
            state        <= S_DONE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        S_DONE: begin
          done   <= 4'b0000;
          grant  <= 4'b0000;
          busy   <= 1'b0;
          wd_cnt <= '0;
          state  <= S_IDLE;
          // Losing side of the data/ins pair becomes preferred next time.
          if (grant[0] || grant[1])
            rr_data <= grant[0];
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_burst_arbiter.sv
// Directed and randomized bench for ddr_burst_arbiter against a transaction-level model.
module tb_ddr_burst_arbiter;
  localparam int AW = 28;
  localparam int LW = 10;
  localparam int TO = 16;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic          calib;
  logic          ins_req, data_req, jmp_req, store_req;
  logic [AW-1:0] ins_addr, data_addr, wr_addr_in;
  logic [7:0]    ins_len;
  logic [LW-1:0] data_len, wr_len_in;
  logic          rd_fin, wr_fin;

  logic          rd_req, wr_req;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [LW-1:0] rd_len, wr_len;
  logic [3:0]    grant, done;
  logic          busy, terr;
  logic [1:0]    state_dbg;

  logic          d_rd_req, d_wr_req;
  logic [AW-1:0] d_rd_addr, d_wr_addr;
  logic [LW-1:0] d_rd_len, d_wr_len;
  logic [3:0]    d_grant, d_done;
  logic          d_busy, d_terr;
  logic [1:0]    d_state;

  ddr_burst_arbiter #(.DDR_ADDR_WIDTH(AW), .BURST_LEN_WIDTH(LW), .TIMEOUT_CYCLES(TO)) u_dut (
    .clk(clk), .rst(rst), .init_calib_complete(calib),
    .ins_read_req(ins_req), .ins_read_addr(ins_addr), .ins_read_len(ins_len),
    .data_read_req(data_req), .data_read_addr(data_addr), .data_read_len(data_len),
    .jmp_addr_read_req(jmp_req), .data_store_req(store_req),
    .data_write_addr(wr_addr_in), .data_write_len(wr_len_in),
    .rd_burst_finish(rd_fin), .wr_burst_finish(wr_fin),
    .rd_burst_req(rd_req), .wr_burst_req(wr_req),
    .rd_burst_addr(rd_addr), .rd_burst_len(rd_len),
    .wr_burst_addr(wr_addr), .wr_burst_len(wr_len),
    .grant(grant), .done(done), .busy(busy), .timeout_err(terr), .state_dbg(state_dbg)
  );

  // Default watchdog instance, used for the long-burst directed case.
  ddr_burst_arbiter #(.DDR_ADDR_WIDTH(AW), .BURST_LEN_WIDTH(LW)) u_dut_def (
    .clk(clk), .rst(rst), .init_calib_complete(calib),
    .ins_read_req(ins_req), .ins_read_addr(ins_addr), .ins_read_len(ins_len),
    .data_read_req(data_req), .data_read_addr(data_addr), .data_read_len(data_len),
    .jmp_addr_read_req(jmp_req), .data_store_req(store_req),
    .data_write_addr(wr_addr_in), .data_write_len(wr_len_in),
    .rd_burst_finish(rd_fin), .wr_burst_finish(wr_fin),
    .rd_burst_req(d_rd_req), .wr_burst_req(d_wr_req),
    .rd_burst_addr(d_rd_addr), .rd_burst_len(d_rd_len),
    .wr_burst_addr(d_wr_addr), .wr_burst_len(d_wr_len),
    .grant(d_grant), .done(d_done), .busy(d_busy), .timeout_err(d_terr), .state_dbg(d_state)
  );

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  bit            m_pref_data;
  bit            m_terr;
  logic [AW-1:0] m_rd_addr, m_wr_addr;
  logic [LW-1:0] m_rd_len, m_wr_len;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_pref_data = 1'b0;
    m_terr      = 1'b0;
    m_rd_addr   = '0;
    m_wr_addr   = '0;
    m_rd_len    = '0;
    m_wr_len    = '0;
  endtask

  task automatic clear_inputs();
    calib = 1'b0; ins_req = 1'b0; data_req = 1'b0; jmp_req = 1'b0; store_req = 1'b0;
    ins_addr = '0; data_addr = '0; wr_addr_in = '0; ins_len = '0; data_len = '0; wr_len_in = '0;
    rd_fin = 1'b0; wr_fin = 1'b0;
  endtask

  task automatic scramble_payload();
    ins_addr   = AW'($urandom);
    data_addr  = AW'($urandom);
    wr_addr_in = AW'($urandom);
    ins_len    = 8'($urandom_range(0, 255));
    data_len   = ($urandom_range(0, 9) == 0) ? '0 : LW'($urandom_range(1, 1023));
    wr_len_in  = ($urandom_range(0, 9) == 0) ? '0 : LW'($urandom_range(1, 1023));
  endtask

  task automatic check_latched(input string tag);
    check({tag, "_rd_addr"}, 32'(rd_addr), 32'(m_rd_addr));
    check({tag, "_rd_len"},  32'(rd_len),  32'(m_rd_len));
    check({tag, "_wr_addr"}, 32'(wr_addr), 32'(m_wr_addr));
    check({tag, "_wr_len"},  32'(wr_len),  32'(m_wr_len));
    check({tag, "_terr"},    32'(terr),    32'(m_terr));
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_grant"},  32'(grant),  32'h0);
    check({tag, "_done"},   32'(done),   32'h0);
    check({tag, "_busy"},   32'(busy),   32'h0);
    check({tag, "_rd_req"}, 32'(rd_req), 32'h0);
    check({tag, "_wr_req"}, 32'(wr_req), 32'h0);
    check_latched(tag);
  endtask

  // Winner index: 3=store, 2=jmp, 1=data, 0=ins, -1=none.
  function automatic int pick_winner();
    if (store_req) return 3;
    if (jmp_req) return 2;
    if (data_req && ins_req) return m_pref_data ? 1 : 0;
    if (data_req) return 1;
    if (ins_req) return 0;
    return -1;
  endfunction

  // Caller is in an IDLE cycle with calib=1 and at least one request high.
  // fin_delay: burst cycle in which the matching finish arrives (0 = never).
  task automatic do_burst(input string tag, input int fin_delay, input bit inject_wrong);
    int            w;
    int            nb;
    bit            is_wr;
    bit            exp_to;
    logic [LW-1:0] len;
    logic [3:0]    onehot;
    w = pick_winner();
    if (w < 0) return;
    onehot = 4'(1 << w);
    is_wr  = (w == 3);
    case (w)
      3:       len = wr_len_in;
      2:       len = LW'(1);
      1:       len = data_len;
      default: len = {2'b00, ins_len};
    endcase
    if (is_wr) begin
      m_wr_addr = wr_addr_in;
      m_wr_len  = len;
    end else begin
      m_rd_addr = (w == 0) ? ins_addr : data_addr;
      m_rd_len  = len;
    end
    if (len == 0) begin
      nb = 1; exp_to = 1'b0;
    end else if (fin_delay >= 1 && fin_delay <= TO) begin
      nb = fin_delay; exp_to = 1'b0;
    end else begin
      nb = TO; exp_to = 1'b1;
    end
    step();
    for (int k = 1; k <= nb; k++) begin
      check({tag, "_b_grant"},  32'(grant),  32'(onehot));
      check({tag, "_b_busy"},   32'(busy),   32'h1);
      check({tag, "_b_done"},   32'(done),   32'h0);
      check({tag, "_b_state"},  32'(state_dbg != 2'd0), 32'h1);
      check({tag, "_b_rd_req"}, 32'(rd_req), 32'(!is_wr && len != 0));
      check({tag, "_b_wr_req"}, 32'(wr_req), 32'(is_wr && len != 0));
      check_latched({tag, "_b"});
      scramble_payload();
      calib  = 1'($urandom_range(0, 1));
      rd_fin = 1'b0;
      wr_fin = 1'b0;
      if (len != 0 && k == fin_delay) begin
        if (is_wr) wr_fin = 1'b1; else rd_fin = 1'b1;
      end else if (len != 0 && inject_wrong && k == 1) begin
        if (is_wr) rd_fin = 1'b1; else wr_fin = 1'b1;
      end
      step();
    end
    rd_fin = 1'b0;
    wr_fin = 1'b0;
    calib  = 1'b1;
    if (exp_to) m_terr = 1'b1;
    check({tag, "_d_done"},   32'(done),   32'(onehot));
    check({tag, "_d_grant"},  32'(grant),  32'(onehot));
    check({tag, "_d_busy"},   32'(busy),   32'h1);
    check({tag, "_d_rd_req"}, 32'(rd_req), 32'h0);
    check({tag, "_d_wr_req"}, 32'(wr_req), 32'h0);
    check_latched({tag, "_d"});
    case (w)
      3:       store_req = 1'b0;
      2:       jmp_req   = 1'b0;
      1:       data_req  = 1'b0;
      default: ins_req   = 1'b0;
    endcase
    if (w <= 1) m_pref_data = (w == 0);
    step();
    check_idle({tag, "_i"});
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    clear_inputs();
    step();
    step();
    model_reset();
    check_idle("rst");
    check("rst_state", 32'(state_dbg), 32'h0);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    model_reset();
    apply_reset();

    // calibration gate: everything requested, nothing granted
    scramble_payload();
    ins_req = 1'b1; data_req = 1'b1; jmp_req = 1'b1; store_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      check_idle("calib_low");
    end
    calib = 1'b1;
    do_burst("first_store", 6, 1'b1);
    do_burst("jmp_after_store", 3, 1'b0);
    for (int i = 0; i < 4; i++) begin
      ins_req = 1'b1; data_req = 1'b1;
      do_burst("rr_pair", int'($urandom_range(1, 8)), 1'b0);
    end
    for (int i = 0; i < 2; i++) begin
      ins_req = 1'b1; data_req = 1'b1; jmp_req = 1'b1;
      do_burst("jmp_prio", 2, 1'b0);
    end
    ins_req = 1'b0; data_req = 1'b0;

    // zero-length data read
    data_req = 1'b1; data_len = '0;
    do_burst("zero_len", 3, 1'b0);

    // watchdog: expiry sets sticky error, finish on last cycle does not
    jmp_req = 1'b1;
    do_burst("finish_at_limit", TO, 1'b0);
    store_req = 1'b1; wr_len_in = LW'(9);
    do_burst("timeout", 0, 1'b1);
    ins_req = 1'b1; ins_len = 8'd4;
    do_burst("sticky", 2, 1'b0);
    apply_reset();

    // mid-burst reset
    calib = 1'b1; ins_req = 1'b1; ins_addr = AW'(28'h0abcdef); ins_len = 8'd50;
    step();
    step();
    step();
    rst = 1'b1;
    step();
    model_reset();
    check_idle("mid_rst");
    check("mid_rst_state", 32'(state_dbg), 32'h0);
    rst = 1'b0;
    clear_inputs();
    step();

    // long instruction burst on the default-watchdog instance
    calib = 1'b1; ins_req = 1'b1; ins_addr = AW'(28'h0000100); ins_len = 8'd72;
    step();
    for (int k = 1; k <= 30; k++) begin
      check("ins30_rd_req", 32'(d_rd_req), 32'h1);
      check("ins30_rd_len", 32'(d_rd_len), 32'd72);
      check("ins30_rd_addr", 32'(d_rd_addr), 32'h100);
      check("ins30_grant", 32'(d_grant), 32'h1);
      check("ins30_done", 32'(d_done), 32'h0);
      rd_fin = (k == 30);
      step();
    end
    rd_fin = 1'b0;
    check("ins30_drop", 32'(d_rd_req), 32'h0);
    check("ins30_done_pulse", 32'(d_done), 32'h1);
    check("ins30_wr_req", 32'(d_wr_req), 32'h0);
    check("ins30_terr", 32'(d_terr), 32'h0);
    ins_req = 1'b0;
    step();
    check("ins30_done_clr", 32'(d_done), 32'h0);
    check("ins30_grant_clr", 32'(d_grant), 32'h0);
    check("ins30_busy", 32'(d_busy), 32'h0);
    check("ins30_state", 32'(d_state), 32'h0);
    check("ins30_wr_addr", 32'(d_wr_addr), 32'h0);
    check("ins30_wr_len", 32'(d_wr_len), 32'h0);
    apply_reset();

    // randomized traffic
    calib = 1'b1;
    for (int t = 0; t < 40; t++) begin
      scramble_payload();
      {store_req, jmp_req, data_req, ins_req} = 4'($urandom_range(1, 15));
      do_burst("rand", int'($urandom_range(0, 20)), 1'($urandom_range(0, 1)));
    end
    ins_req = 1'b0; data_req = 1'b0; jmp_req = 1'b0; store_req = 1'b0;
    step();
    check_idle("final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
